// File: rtl/debounced_encoder_pkg.sv
// Shared constants, debounce FSM state type and the priority-encode helper
// for the debounced push-button encoder.
package debounced_encoder_pkg;

    localparam int N_IN              = 4;
    localparam int CODE_W            = 2;
    localparam int DB_CYCLES_DEF     = 1_000_000;   // 10 ms at 100 MHz
    localparam int REPEAT_CYCLES_DEF = 25_000_000;  // 250 ms at 100 MHz

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_e;

    // Index of the highest set bit; 0 when no bit is set.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [N_IN-1:0] lv);
        prio_enc = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (lv[i]) begin
                prio_enc = CODE_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/debounced_encoder_if.sv
// Button-side bundle: raw inputs in, debounced levels, code, valid and press
// strobe out. The encoder itself connects through the slave modport.
interface debounced_encoder_if;
    import debounced_encoder_pkg::*;

    logic [N_IN-1:0]   btn_in;
    logic [N_IN-1:0]   btn_db;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              press_stb;

    modport master (
        output btn_in,
        input  btn_db, code, valid, press_stb
    );

    modport slave (
        input  btn_in,
        output btn_db, code, valid, press_stb
    );

endinterface

// File: rtl/debounced_encoder_debounce_cell.sv
// One input lane: 2-flop synchroniser followed by a STABLE/COUNTING debounce
// FSM. The debounced level flips only after DB_CYCLES consecutive synchronised
// samples disagree with it; any agreeing sample abandons the count.
module debounce_cell
    import debounced_encoder_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = $clog2(DB_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    db_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             db_q;

    // Synchronise the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce FSM; the counter tops out at DB_CYCLES-1 so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= '0;
            db_q  <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (sync_p1 != db_q) begin
                        state <= COUNTING;
                        cnt   <= CNT_W'(1);
                    end
                end
                COUNTING: begin
                    if (sync_p1 == db_q) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                        db_q  <= ~db_q;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign db = db_q;

endmodule

// File: rtl/debounced_encoder.sv
// Debounced priority encoder: four debounced button lanes feed a registered
// priority encoder with a level "any active" flag and a one-cycle press strobe.
// Optional build macro ENC_REPEAT_EN adds auto-repeat of press_stb every
// REPEAT_CYCLES cycles while a code is held; without it the strobe fires only
// on debounced rising edges.
module debounced_encoder
    import debounced_encoder_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input logic               clk,
    input logic               rst,
    debounced_encoder_if.slave bus
);

    if (DB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("debounced_encoder: DB_CYCLES and REPEAT_CYCLES must be at least 2");
    end

    logic [N_IN-1:0]   db;
    logic [N_IN-1:0]   db_p1;
    logic [CODE_W-1:0] code_nxt;
    logic [CODE_W-1:0] code_p1;
    logic              valid_nxt;
    logic              valid_p1;
    logic              rise;
    logic              stb_p1;

    for (genvar i = 0; i < N_IN; i++) begin : g_cell
        debounce_cell #(
            .DB_CYCLES(DB_CYCLES)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .raw(bus.btn_in[i]),
            .db (db[i])
        );
    end

    // Next encoder outputs and rising-edge detect on the debounced levels.
    always_comb begin
        code_nxt  = prio_enc(db);
        valid_nxt = |db;
        rise      = |(db & ~db_p1);
    end

    // Encoder output registers plus the previous-cycle copy for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_p1    <= '0;
            code_p1  <= '0;
            valid_p1 <= 1'b0;
        end else begin
            db_p1    <= db;
            code_p1  <= code_nxt;
            valid_p1 <= valid_nxt;
        end
    end

`ifdef ENC_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);

    logic [RPT_W-1:0] rpt_cnt;

    // Strobe on rises; while a code is held, re-strobe every REPEAT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt <= '0;
            stb_p1  <= 1'b0;
        end else if (rise || (code_nxt != code_p1) || !valid_nxt) begin
            rpt_cnt <= '0;
            stb_p1  <= rise;
        end else if (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1)) begin
            rpt_cnt <= '0;
            stb_p1  <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
            stb_p1  <= 1'b0;
        end
    end
`else
    // Strobe once on any debounced rise; releases never strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_p1 <= 1'b0;
        end else begin
            stb_p1 <= rise;
        end
    end
`endif

    assign bus.btn_db    = db;
    assign bus.code      = code_p1;
    assign bus.valid     = valid_p1;
    assign bus.press_stb = stb_p1;

endmodule

// File: tb/tb_debounced_encoder.sv
// Bench for debounced_encoder with DB_CYCLES=4, REPEAT_CYCLES=10. A run-length
// reference model tracks the expected outputs cycle by cycle.
module tb_debounced_encoder;
    import debounced_encoder_pkg::*;

    localparam int DB = 4;
    localparam int RP = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debounced_encoder_if bus ();

    debounced_encoder #(
        .DB_CYCLES    (DB),
        .REPEAT_CYCLES(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_db_last = '0;
    logic [1:0] m_code = '0;
    logic       m_valid = 1'b0, m_stb = 1'b0;
    int         run [4] = '{0, 0, 0, 0};
    int         cyc = 0;
`ifdef ENC_REPEAT_EN
    int         anchor = 0;
`endif

    function automatic logic [1:0] top_index(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic [7:0] observed();
        return {bus.btn_db, bus.code, bus.valid, bus.press_stb};
    endfunction

    function automatic logic [7:0] expected();
        return {m_db, m_code, m_valid, m_stb};
    endfunction

    // One clock edge of the reference: an input level is accepted once the
    // synchronised sample has disagreed with it DB times in a row.
    task automatic model_edge(input logic [3:0] raw, input logic r);
        logic [3:0] d;
        logic       rise;
        logic [1:0] nc;
        logic       nv;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_db_last = '0;
            m_code = '0; m_valid = 1'b0; m_stb = 1'b0;
            for (int i = 0; i < 4; i++) run[i] = 0;
        end else begin
            d    = m_db;
            rise = (d & ~m_db_last) != 4'd0;
            nc   = top_index(d);
            nv   = (d != 4'd0);
`ifdef ENC_REPEAT_EN
            if (rise || nc != m_code) begin
                anchor = cyc;
                m_stb  = rise;
            end else begin
                m_stb = nv && (((cyc - anchor) % RP) == 0);
            end
`else
            m_stb = rise;
`endif
            m_code    = nc;
            m_valid   = nv;
            m_db_last = d;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != d[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        m_db[i] = ~m_db[i];
                        run[i]  = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        cyc++;
    endtask

    task automatic tick(input logic [3:0] raw, input logic r);
        bus.btn_in = raw;
        rst        = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
    endtask

    task automatic test_reset();
        int first = -1;
        int nstb  = 0;
        for (int i = 0; i < 14; i++) begin
            tick(4'hF, i < 5);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL reset_seq i=%0d got=%h want=%h", i, observed(), expected());
            end
            if (i == 4) begin
                checks++;
                if (observed() !== 8'h00) begin
                    failures++;
                    $display("FAIL reset_zero got=%h want=00", observed());
                end
            end
            if (i >= 5 && bus.press_stb === 1'b1) begin
                nstb++;
                if (first < 0) first = i - 5;
            end
        end
        checks++;
        if (first !== 6) begin
            failures++;
            $display("FAIL reset_stb_latency got=%0d want=6", first);
        end
        checks++;
        if (nstb !== 1) begin
            failures++;
            $display("FAIL reset_stb_count got=%0d want=1", nstb);
        end
        checks++;
        if ({bus.code, bus.valid} !== 3'b111) begin
            failures++;
            $display("FAIL reset_code_valid got=%b want=111", {bus.code, bus.valid});
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 25; i++) begin
            tick((i >= 12 && i < 15) ? 4'b0010 : 4'b0000, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL glitch_seq i=%0d got=%h want=%h", i, observed(), expected());
            end
            if (i >= 12) begin
                checks++;
                if (observed() !== 8'h00) begin
                    failures++;
                    $display("FAIL glitch_quiet i=%0d got=%h want=00", i, observed());
                end
            end
        end
    endtask

    task automatic test_single_press();
        int nstb = 0;
        for (int i = 0; i < 32; i++) begin
            tick((i >= 12 && i < 20) ? 4'b0100 : 4'b0000, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL press_seq i=%0d got=%h want=%h", i, observed(), expected());
            end
            if (i >= 12 && bus.press_stb === 1'b1) nstb++;
            if (i == 17) begin
                checks++;
                if (bus.btn_db !== 4'b0100) begin
                    failures++;
                    $display("FAIL press_db_E5 got=%b want=0100", bus.btn_db);
                end
            end
            if (i == 18) begin
                checks++;
                if ({bus.code, bus.valid, bus.press_stb} !== 4'b1011) begin
                    failures++;
                    $display("FAIL press_out_E6 got=%b want=1011", {bus.code, bus.valid, bus.press_stb});
                end
            end
        end
        checks++;
        if (nstb !== 1) begin
            failures++;
            $display("FAIL press_stb_count got=%0d want=1", nstb);
        end
        checks++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL press_release_valid got=%b want=0", bus.valid);
        end
    endtask

    task automatic test_priority();
        int nstb_on  = 0;
        int nstb_low = 0;
        for (int i = 0; i < 36; i++) begin
            tick((i < 12) ? 4'b0000 : (i < 20) ? 4'b1010 : 4'b0010, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL prio_seq i=%0d got=%h want=%h", i, observed(), expected());
            end
            if (i >= 12 && i < 20 && bus.press_stb === 1'b1) nstb_on++;
            if (i >= 20 && bus.press_stb === 1'b1) nstb_low++;
            if (i == 18) begin
                checks++;
                if ({bus.code, bus.press_stb} !== 3'b111) begin
                    failures++;
                    $display("FAIL prio_code3 got=%b want=111", {bus.code, bus.press_stb});
                end
            end
        end
        checks++;
        if (nstb_on !== 1 || nstb_low !== 0) begin
            failures++;
            $display("FAIL prio_stb_count got=%0d/%0d want=1/0", nstb_on, nstb_low);
        end
        checks++;
        if ({bus.code, bus.valid} !== 3'b011) begin
            failures++;
            $display("FAIL prio_drop got=%b want=011", {bus.code, bus.valid});
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        for (int i = 0; i < 30; i++) begin
            tick((i < 12) ? 4'b0000 : 4'b0001, i == 14);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL rstmid_seq i=%0d got=%h want=%h", i, observed(), expected());
            end
            if (i >= 12 && i < 19) begin
                checks++;
                if (observed() !== 8'h00) begin
                    failures++;
                    $display("FAIL rstmid_quiet i=%0d got=%h want=00", i, observed());
                end
            end
            if (first < 0 && bus.press_stb === 1'b1) first = i;
        end
        checks++;
        if (first !== 21) begin
            failures++;
            $display("FAIL rstmid_stb_at got=%0d want=21", first);
        end
    endtask

    task automatic test_repeat();
        int got_q [$];
        int exp_q [$];
`ifdef ENC_REPEAT_EN
        exp_q = '{18, 28, 38};
`else
        exp_q = '{18};
`endif
        for (int i = 0; i < 56; i++) begin
            tick((i >= 12 && i < 40) ? 4'b0100 : 4'b0000, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL repeat_seq i=%0d got=%h want=%h", i, observed(), expected());
            end
            if (bus.press_stb === 1'b1) got_q.push_back(i);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL repeat_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (got_q[k] != exp_q[k]) begin
                    failures++;
                    $display("FAIL repeat_at k=%0d got=%0d want=%0d", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] pat;
        logic       r;
        int         len;
        int         done = 0;
        while (done < 600) begin
            pat = 4'($urandom_range(0, 15));
            r   = ($urandom_range(0, 40) == 0);
            len = r ? 1 : int'($urandom_range(1, 9));
            for (int k = 0; k < len; k++) begin
                tick(pat, r);
                done++;
                checks++;
                if (observed() !== expected()) begin
                    failures++;
                    $display("FAIL random_seq n=%0d got=%h want=%h", done, observed(), expected());
                end
            end
        end
    endtask

    initial begin
        bus.btn_in = '0;
        test_reset();
        test_glitch();
        test_single_press();
        test_priority();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounced_encoder.md
# debounced_encoder

Registered priority encoder for the board's raw push-button or switch inputs. It synchronises and debounces each of four asynchronous inputs, then priority-encodes the debounced levels into a 2-bit code. It also produces a level "any active" flag and a one-cycle press strobe. It sits between the board pins (btn/sw) and downstream logic that consumes codes, mirroring the display decode path on the input side.

## Interface
- DB_CYCLES, 1_000_000: consecutive stable cycles required to accept a new input level (10 ms at 100 MHz); minimum 2.
- REPEAT_CYCLES, 25_000_000: auto-repeat period; used only with ENC_REPEAT_EN.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  4  raw asynchronous inputs; bit 3 has highest priority.
- btn_db  out  4  debounced levels.
- code  out  2  index of highest set bit of btn_db; 0 when none set.
- valid  out  1  high while any btn_db bit is set.
- press_stb  out  1  one-cycle pulse on each accepted press event.

## Operation
- Per input: 2-flop synchroniser → debounce_cell → btn_db bit.
- debounce_cell states: STABLE, COUNTING.
  - STABLE: if sync != btn_db bit → COUNTING, counter=1.
  - COUNTING: if sync == btn_db bit (glitch) → STABLE, counter=0.
  - COUNTING: else if counter == DB_CYCLES-1 → toggle btn_db bit, → STABLE, counter=0.
  - COUNTING: else counter+1.
- Counter width: $clog2(DB_CYCLES); it never wraps.
- Encoder, registered, combining btn_db:
  - code = highest set index.
  - valid = |btn_db.
  - press_stb = 1 iff any btn_db bit rose in the previous cycle.
- Simultaneous rises on several bits: one strobe; code = highest index.
- Release of a higher bit while a lower bit is held: code drops to the lower index, valid stays 1, no strobe.
- Releases never strobe.
- Reset values: btn_db=0, code=0, valid=0, press_stb=0, all counters 0, all cells STABLE, synchroniser flops 0.
- rst mid-count discards the count. After release of rst, an input already high is re-debounced from zero and produces a press strobe.

## Timing
- Raw level captured by sync flop 1 at edge E.
- btn_db changes at edge E+DB_CYCLES+1.
- code/valid/press_stb update at edge E+DB_CYCLES+2.
- Any sync-stage bounce shorter than DB_CYCLES cycles produces no output change.
- press_stb is exactly one cycle wide.
- Minimum spacing between strobes on one input: 2·DB_CYCLES cycles (press + release).

## Configuration
- ENC_REPEAT_EN defined: while valid stays high with no new rise, a repeat counter generates press_stb every REPEAT_CYCLES cycles.
  - The first repeat fires REPEAT_CYCLES cycles after the original strobe.
  - Any new rise or a change of code restarts the repeat counter.
  - The counter clears when valid falls, and on reset.
- ENC_REPEAT_EN undefined: no repeat logic; press_stb fires only on debounced rises.

## Structure
- Package debounced_encoder_pkg:
  - N_IN=4, CODE_W=2.
  - Default DB_CYCLES and REPEAT_CYCLES constants.
  - debounce state enum {STABLE, COUNTING}.
- Sub-module debounce_cell: one synchroniser, FSM and counter per input, parameterised by DB_CYCLES; instantiated N_IN times.
- Priority encode, edge detection and repeat logic live in the top.

## Test plan
Benches run with DB_CYCLES=4, REPEAT_CYCLES=10.
- Reset: hold rst with btn_in=4'hF → all outputs 0. Release rst → press_stb pulses once, code=3, valid=1, 6 cycles after the first capture.
- Glitch reject: btn_in[1] high for 3 cycles, then low → btn_db, code, valid and press_stb stay 0 throughout.
- Single press: btn_in=4'b0100 held → btn_db=4'b0100 at E+5; code=2, valid=1 and one press_stb at E+6. Release → valid=0 after debounce, no strobe.
- Simultaneous/priority: btn_in 0→4'b1010 in one cycle → one strobe, code=3. Drop bit 3 → code=1, valid=1, no strobe.
- Reset mid-count: btn_in[0] rises, rst asserted 2 cycles later for 1 cycle → no output change until a full fresh 4-cycle debounce completes after rst.
- With ENC_REPEAT_EN: hold btn_in[2] → strobes at E+6, E+16, E+26. Release → no further strobes.
